// File: rtl/coin_pkg.sv
// Shared types and default constants for the 50-cent coin acceptor.
package coin_pkg;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DEB_CYCLES_DEF   = 4;
  localparam int MIN_CYCLES_DEF   = 8;
  localparam int MAX_CYCLES_DEF   = 64;
  localparam int PULSE_CYCLES_DEF = 3;
  localparam int GAP_CYCLES_DEF   = 2;

  localparam logic [1:0] CREDIT_FULL = 2'd3;
  localparam logic [7:0] COIN_CNT_SAT = 8'd255;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_HIGH = 2'd1,
    M_LONG = 2'd2
  } meas_state_t;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_PULSE = 2'd1,
    O_GAP   = 2'd2
  } out_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Synchronizer chain followed by a run-length debouncer for the coin sensor.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic ares_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The level only flips after DEB_CYCLES consecutive opposite samples.
  always_ff @(posedge clk_i or posedge ares_i) begin
    if (ares_i) begin
      sync_q  <= '0;
      run_q   <= '0;
      level_o <= 1'b0;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      if (sync_s == level_o) begin
        run_q <= '0;
      end else if (run_q == CW'(DEB_CYCLES - 1)) begin
        level_o <= sync_s;
        run_q   <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures debounced coin width, banks credits and emits
// fixed-width ct50 pulses with a mandatory low gap between them.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int MIN_CYCLES   = MIN_CYCLES_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       ares_i,
  input  logic       coin_raw_i,
  output logic       ct50_o,
  output logic       rej_o,
  output logic       busy_o,
  output logic [7:0] coin_cnt_o,
  output logic [1:0] meas_state_o,
  output logic [1:0] out_state_o
);

  localparam int WW   = $clog2(MAX_CYCLES + 2);
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  logic          level;
  meas_state_t   meas_q, meas_d;
  logic [WW-1:0] width_q, width_d;
  out_state_t    out_q, out_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    credit_q, credit_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          accept, meas_rej, ovf_rej, dec;
  logic          ct50_q, rej_q;

  coin_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk_i  (clk_i),
    .ares_i (ares_i),
    .raw_i  (coin_raw_i),
    .level_o(level)
  );

  always_comb begin
    meas_d   = meas_q;
    width_d  = width_q;
    accept   = 1'b0;
    meas_rej = 1'b0;
    unique case (meas_q)
      M_IDLE: begin
        if (level) begin
          meas_d  = M_HIGH;
          width_d = WW'(1);
        end
      end
      M_HIGH: begin
        if (level) begin
          // One cycle past MAX is an overlong coin: reject now, not at release.
          if (width_q == WW'(MAX_CYCLES)) begin
            meas_rej = 1'b1;
            meas_d   = M_LONG;
          end else begin
            width_d = width_q + 1'b1;
          end
        end else begin
          if (width_q >= WW'(MIN_CYCLES)) accept = 1'b1;
          else                             meas_rej = 1'b1;
          meas_d = M_IDLE;
        end
      end
      M_LONG: begin
        if (!level) meas_d = M_IDLE;
      end
      default: meas_d = M_IDLE;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    tcnt_d = tcnt_q;
    dec    = 1'b0;
    unique case (out_q)
      O_IDLE: begin
        if (credit_q != 2'd0) begin
          out_d  = O_PULSE;
          tcnt_d = '0;
          dec    = 1'b1;
        end
      end
      O_PULSE: begin
        if (tcnt_q == TW'(PULSE_CYCLES - 1)) begin
          out_d  = O_GAP;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      O_GAP: begin
        if (tcnt_q == TW'(GAP_CYCLES - 1)) begin
          out_d  = O_IDLE;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: out_d = O_IDLE;
    endcase
  end

  // A same-cycle decrement frees the slot, so a full bank can still take the coin.
  always_comb begin
    credit_d = credit_q;
    cnt_d    = cnt_q;
    ovf_rej  = 1'b0;
    if (accept) begin
      if ((credit_q == CREDIT_FULL) && !dec) begin
        ovf_rej = 1'b1;
      end else begin
        if (!dec) credit_d = credit_q + 2'd1;
        if (cnt_q != COIN_CNT_SAT) cnt_d = cnt_q + 8'd1;
      end
    end else if (dec) begin
      credit_d = credit_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge ares_i) begin
    if (ares_i) begin
      meas_q   <= M_IDLE;
      width_q  <= '0;
      out_q    <= O_IDLE;
      tcnt_q   <= '0;
      credit_q <= 2'd0;
      cnt_q    <= 8'd0;
      ct50_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      meas_q   <= meas_d;
      width_q  <= width_d;
      out_q    <= out_d;
      tcnt_q   <= tcnt_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      ct50_q   <= (out_d == O_PULSE);
      rej_q    <= meas_rej | ovf_rej;
    end
  end

  assign ct50_o       = ct50_q;
  assign rej_o        = rej_q;
  assign busy_o       = (credit_q != 2'd0) || (out_q != O_IDLE);
  assign coin_cnt_o   = cnt_q;
  assign meas_state_o = meas_q;
  assign out_state_o  = out_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench: instance 0 uses defaults, instance 1 uses long pulses so credits pile up.
module tb_coin_acceptor;

  logic       clk_i;
  logic       raw [2];
  logic       ares [2];
  logic       ct50 [2];
  logic       rej [2];
  logic       busy [2];
  logic [7:0] coin_cnt [2];
  logic [1:0] meas_st [2];
  logic [1:0] out_st [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int pulses[2]    = '{0, 0};
  int rejs[2]      = '{0, 0};
  int dbl[2]       = '{0, 0};
  int last_rej[2]  = '{-1, -1};
  int last_acc[2]  = '{-1, -1};
  int last_rise[2] = '{-1, -1};
  int min_w[2]     = '{9999, 9999};
  int max_w[2]     = '{0, 0};
  int min_gap[2]   = '{9999, 9999};
  int last_tail[2] = '{-1, -1};
  int hi_run[2]    = '{0, 0};
  int lo_run[2]    = '{0, 0};
  int tcnt[2]      = '{0, 0};
  bit in_gap[2]    = '{0, 0};
  bit in_tail[2]   = '{0, 0};
  logic prev_ct[2]  = '{1'b0, 1'b0};
  logic prev_rej[2] = '{1'b0, 1'b0};
  logic [7:0] prev_cnt[2] = '{8'd0, 8'd0};

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  coin_acceptor u_dut_a (
    .clk_i       (clk_i),
    .ares_i      (ares[0]),
    .coin_raw_i  (raw[0]),
    .ct50_o      (ct50[0]),
    .rej_o       (rej[0]),
    .busy_o      (busy[0]),
    .coin_cnt_o  (coin_cnt[0]),
    .meas_state_o(meas_st[0]),
    .out_state_o (out_st[0])
  );

  coin_acceptor #(
    .PULSE_CYCLES(40),
    .GAP_CYCLES  (10)
  ) u_dut_b (
    .clk_i       (clk_i),
    .ares_i      (ares[1]),
    .coin_raw_i  (raw[1]),
    .ct50_o      (ct50[1]),
    .rej_o       (rej[1]),
    .busy_o      (busy[1]),
    .coin_cnt_o  (coin_cnt[1]),
    .meas_state_o(meas_st[1]),
    .out_state_o (out_st[1])
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  always @(negedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (ct50[i] && !prev_ct[i]) begin
        pulses[i]++;
        last_rise[i] = cyc;
        if (in_gap[i] && lo_run[i] < min_gap[i]) min_gap[i] = lo_run[i];
        in_gap[i] = 1'b0;
        hi_run[i] = 0;
      end
      if (!ct50[i] && prev_ct[i]) begin
        if (hi_run[i] < min_w[i]) min_w[i] = hi_run[i];
        if (hi_run[i] > max_w[i]) max_w[i] = hi_run[i];
        in_gap[i]  = 1'b1;
        lo_run[i]  = 0;
        in_tail[i] = 1'b1;
        tcnt[i]    = 0;
      end
      if (ct50[i]) begin
        hi_run[i]++;
        in_tail[i] = 1'b0;
      end else begin
        if (in_gap[i]) lo_run[i]++;
        if (in_tail[i]) begin
          if (busy[i]) tcnt[i]++;
          else begin
            last_tail[i] = tcnt[i];
            in_tail[i]   = 1'b0;
          end
        end
      end
      if (ares[i]) begin
        in_gap[i]  = 1'b0;
        in_tail[i] = 1'b0;
      end
      if (rej[i]) begin
        rejs[i]++;
        last_rej[i] = cyc;
        if (prev_rej[i]) dbl[i]++;
      end
      if (coin_cnt[i] != prev_cnt[i]) begin
        last_acc[i] = cyc;
        if (i == 0 && !ares[i]) obs_q.push_back(coin_cnt[i]);
      end
      prev_ct[i]  = ct50[i];
      prev_rej[i] = rej[i];
      prev_cnt[i] = coin_cnt[i];
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  // Drives one coin: hi cycles high, then lo cycles low; returns the cycle of the drop.
  task automatic coin(input int sel, input int hi, input int lo, output int drop);
    raw[sel] = 1'b1;
    repeat (hi) @(negedge clk_i);
    #1;
    raw[sel] = 1'b0;
    drop = cyc;
    repeat (lo) @(negedge clk_i);
    #1;
  endtask

  task automatic glitch(input int sel, input int n);
    repeat (n) begin
      raw[sel] = 1'b1;
      idle(1);
      raw[sel] = 1'b0;
      idle(1);
    end
  endtask

  int drop, drop6, p0, r0, p1, r1;
  int lows_b[6] = '{4, 4, 4, 8, 4, 4};

  initial begin
    raw[0] = 1'b0; raw[1] = 1'b0;
    ares[0] = 1'b1; ares[1] = 1'b1;
    idle(3);
    check("rst_ct50", ct50[0], 0);
    check("rst_rej", rej[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_cnt", coin_cnt[0], 0);
    check("rst_meas", meas_st[0], 0);
    check("rst_out", out_st[0], 0);
    ares[0] = 1'b0; ares[1] = 1'b0;
    idle(5);

    // clean 20-cycle coin
    p0 = pulses[0]; r0 = rejs[0];
    coin(0, 20, 30, drop);
    exp_q.push_back(8'd1);
    check("clean_cnt", coin_cnt[0], 1);
    check("clean_acc_cyc", last_acc[0], drop + 7);
    check("clean_rise_cyc", last_rise[0], drop + 8);
    check("clean_pulses", pulses[0] - p0, 1);
    check("clean_width", max_w[0], 3);
    check("clean_gap", last_tail[0], 2);
    check("clean_rej", rejs[0] - r0, 0);
    check("clean_busy", busy[0], 0);

    // glitches alone, then glitches ahead of a real coin
    r0 = rejs[0];
    glitch(0, 3);
    idle(10);
    check("glitch_meas", meas_st[0], 0);
    check("glitch_cnt", coin_cnt[0], 1);
    check("glitch_rej", rejs[0] - r0, 0);
    p0 = pulses[0];
    glitch(0, 3);
    coin(0, 20, 30, drop);
    exp_q.push_back(8'd2);
    check("bounce_cnt", coin_cnt[0], 2);
    check("bounce_acc_cyc", last_acc[0], drop + 7);
    check("bounce_pulses", pulses[0] - p0, 1);
    check("bounce_rej", rejs[0] - r0, 0);

    // short coin
    p0 = pulses[0]; r0 = rejs[0];
    coin(0, 5, 30, drop);
    check("short_rej", rejs[0] - r0, 1);
    check("short_rej_cyc", last_rej[0], drop + 7);
    check("short_cnt", coin_cnt[0], 2);
    check("short_pulses", pulses[0] - p0, 0);
    check("short_busy", busy[0], 0);

    // exactly MAX wide is still valid
    r0 = rejs[0];
    coin(0, 64, 30, drop);
    exp_q.push_back(8'd3);
    check("max_cnt", coin_cnt[0], 3);
    check("max_rej", rejs[0] - r0, 0);

    // overlong coin: reject at width 65, nothing at release
    p0 = pulses[0]; r0 = rejs[0];
    coin(0, 100, 30, drop);
    check("long_rej", rejs[0] - r0, 1);
    check("long_rej_cyc", last_rej[0], drop - 100 + 71);
    check("long_pulses", pulses[0] - p0, 0);
    check("long_cnt", coin_cnt[0], 3);
    check("long_meas", meas_st[0], 0);

    // five coins at minimum spacing; output drains faster than coins arrive
    p0 = pulses[0]; r0 = rejs[0];
    for (int k = 0; k < 5; k++) begin
      coin(0, 8, 4, drop);
      exp_q.push_back(8'(4 + k));
    end
    idle(40);
    check("five_cnt", coin_cnt[0], 8);
    check("five_pulses", pulses[0] - p0, 5);
    check("five_rej", rejs[0] - r0, 0);
    check("a_pulses_eq_cnt", pulses[0], coin_cnt[0]);
    check("a_min_width", min_w[0], 3);
    check("a_gap", last_tail[0], 2);
    check("a_rej_double", dbl[0], 0);

    // long-pulse instance: coincident accept at full bank, then overflow
    for (int k = 0; k < 6; k++) coin(1, 8, lows_b[k], drop);
    drop6 = drop;
    idle(220);
    check("b_cnt", coin_cnt[1], 5);
    check("b_rej", rejs[1], 1);
    check("b_rej_cyc", last_rej[1], drop6 + 7);
    check("b_pulses_eq_cnt", pulses[1], 5);
    check("b_min_width", min_w[1], 40);
    check("b_max_width", max_w[1], 40);
    check("b_min_gap", min_gap[1], 11);
    check("b_busy", busy[1], 0);

    // reset mid-pulse with two credits still banked
    for (int k = 0; k < 3; k++) coin(1, 8, 4, drop);
    idle(6);
    check("pre_rst_ct50", ct50[1], 1);
    check("pre_rst_busy", busy[1], 1);
    check("pre_rst_cnt", coin_cnt[1], 8);
    ares[1] = 1'b1;
    #1;
    check("mid_rst_ct50", ct50[1], 0);
    check("mid_rst_busy", busy[1], 0);
    check("mid_rst_rej", rej[1], 0);
    check("mid_rst_cnt", coin_cnt[1], 0);
    check("mid_rst_out", out_st[1], 0);
    idle(3);
    ares[1] = 1'b0;
    p1 = pulses[1]; r1 = rejs[1];
    idle(150);
    check("post_rst_pulses", pulses[1] - p1, 0);
    check("post_rst_rej", rejs[1] - r1, 0);
    check("post_rst_ct50", ct50[1], 0);
    check("post_rst_busy", busy[1], 0);
    check("post_rst_cnt", coin_cnt[1], 0);

    // scoreboard: accepted-coin count sequence on instance 0
    check("sb_len", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check("sb_acc", obs_q.pop_front(), exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on coin_raw_i.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive equal synchronized samples needed to change the debounced level.
REQ-003 Parameter MIN_CYCLES, default 8: minimum valid debounced high width, in cycles.
REQ-004 Parameter MAX_CYCLES, default 64: maximum valid debounced high width, in cycles.
REQ-005 Parameter PULSE_CYCLES, default 3: ct50_o high time per credit.
REQ-006 Parameter GAP_CYCLES, default 2: mandatory ct50_o low time after each pulse.
REQ-007 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-008 ares_i  input  1  asynchronous, active-high reset.
REQ-009 coin_raw_i  input  1  raw, asynchronous, bouncy 50-cent coin sensor (high = coin in slot).
REQ-010 ct50_o  output  1  clean coin pulse to the downstream vending controller's ct50_i.
REQ-011 rej_o  output  1  one-cycle pulse per rejected coin event.
REQ-012 busy_o  output  1  high when credit counter is non-zero or the output FSM is not idle.
REQ-013 coin_cnt_o  output  8  count of accepted coins, saturating at 255.

Function
REQ-014 coin_raw_i shall pass through SYNC_STAGES flops before any other use.
REQ-015 Debounced level shall change only after DEB_CYCLES consecutive synchronized samples differ from it; any opposite sample restarts the run.
REQ-016 Measure FSM states: M_IDLE, M_HIGH, M_LONG.
REQ-017 M_IDLE -> M_HIGH on debounced rise; width counter loads 1.
REQ-018 M_HIGH: width counter increments each cycle the debounced level is high.
REQ-019 M_HIGH: on debounced fall with MIN_CYCLES <= width <= MAX_CYCLES, accept and go to M_IDLE.
REQ-020 M_HIGH: on debounced fall with width < MIN_CYCLES, pulse rej_o and go to M_IDLE.
REQ-021 M_HIGH: when width would exceed MAX_CYCLES, pulse rej_o once and go to M_LONG; M_LONG -> M_IDLE on debounced fall with no further rej_o.
REQ-022 Width counter width shall be clog2(MAX_CYCLES+2); it never wraps.
REQ-023 Credit counter 2 bits, range 0..3; accept increments it on the edge registering the accept.
REQ-024 An accept with credit = 3 and no same-cycle decrement shall not increment the credit, shall not increment coin_cnt_o, and shall pulse rej_o.
REQ-025 Same-cycle accept and output-FSM decrement shall leave credit unchanged, including at credit = 3; the accept counts.
REQ-026 Output FSM states: O_IDLE, O_PULSE, O_GAP.
REQ-027 O_IDLE with credit > 0 -> O_PULSE and decrement credit; ct50_o is high for exactly PULSE_CYCLES cycles.
REQ-028 O_PULSE -> O_GAP, with ct50_o low for exactly GAP_CYCLES cycles, then -> O_IDLE.
REQ-029 ct50_o shall be driven from a flop and rise on the edge after the accept edge when the output FSM is in O_IDLE.
REQ-030 coin_cnt_o increments by 1 per counted accept and holds at 255.
REQ-031 rej_o shall never be high in two consecutive cycles for one coin event.

Reset
REQ-032 ares_i high shall immediately clear synchronizer, debouncer (level 0), both FSMs (M_IDLE, O_IDLE), width and credit counters, and coin_cnt_o.
REQ-033 During reset, ct50_o = 0, rej_o = 0, busy_o = 0, coin_cnt_o = 0.
REQ-034 Reset asserted mid-pulse shall drop ct50_o at once and discard pending credits.
REQ-035 A coin already high at reset release shall be measured from its debounced rise after release.

Structure
REQ-036 Shared package coin_pkg shall hold the meas_state_t and out_state_t enums and the default parameter constants.
REQ-037 The debouncer shall be sub-module coin_debounce (synchronizer plus debounce counter); the FSMs and counters stay in coin_acceptor.

Verification
REQ-038 Clean 20-cycle high -> one ct50_o pulse of 3 cycles, then at least 2 low cycles; coin_cnt_o = 1; rej_o never high.
REQ-039 Bounce of 1-cycle glitches at the start, then 20 cycles stable high -> exactly one accept; glitches alone -> debounced level unchanged.
REQ-040 5-cycle debounced high -> rej_o pulses once at the fall; credit and coin_cnt_o unchanged.
REQ-041 100-cycle high -> rej_o once, at debounced width 65; no ct50_o; no second rej_o at release.
REQ-042 Five valid coins back-to-back at minimum spacing -> accepts and rejects follow REQ-024/025; exactly one rej_o if credit overflows; ct50_o pulse count equals coin_cnt_o.
REQ-043 Reset pulse asserted during O_PULSE with credit = 2 -> ct50_o = 0 that cycle; no pulses after release; all outputs 0.
